// File: rtl/id_stage.sv
// Instruction-decode stage for a 5-stage MIPS-style pipeline.
// Contains the register file, control decode, hazard stall, branch/jump resolution and a stall counter.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_write_reg,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_write_reg,
  output logic        mem_write,
  output logic        mem_read,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        ALU_src,
  output logic [2:0]  ALU_op,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] imm_sext,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        stall,
  output logic        flush_if,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [15:0] stall_count
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic            wr_en;
  logic            is_rtype;
  logic            is_sw;
  logic            is_beq;
  logic            is_j;
  logic            load_use;
  logic            beq_haz;
  logic            unused_shamt;

  logic            dec_mem_write;
  logic            dec_mem_read;
  logic            dec_reg_write;
  logic            dec_reg_dst;
  logic            dec_mem_to_reg;
  logic            dec_alu_src;
  logic [2:0]      dec_alu_op;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
  assign unused_shamt = ^instr[10:6];

  // Writes are suppressed during reset so write-through also stays quiet
  assign wr_en = rst_n && wb_reg_write && (wb_write_reg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wb_write_reg] = wb_write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data1 = regs_q[rs];
    read_data2 = regs_q[rt];
    if (wr_en && (wb_write_reg == rs)) read_data1 = wb_write_data;
    if (wr_en && (wb_write_reg == rt)) read_data2 = wb_write_data;
    if (rs == 5'd0) read_data1 = '0;
    if (rt == 5'd0) read_data2 = '0;
  end

  // Raw control decode; unsupported opcode/funct leaves everything at 0 (bubble)
  always_comb begin
    dec_mem_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_alu_op     = ALU_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD: begin dec_reg_write = 1'b1; dec_reg_dst = 1'b1; dec_alu_op = ALU_ADD; end
          FN_SUB: begin dec_reg_write = 1'b1; dec_reg_dst = 1'b1; dec_alu_op = ALU_SUB; end
          FN_AND: begin dec_reg_write = 1'b1; dec_reg_dst = 1'b1; dec_alu_op = ALU_AND; end
          FN_OR:  begin dec_reg_write = 1'b1; dec_reg_dst = 1'b1; dec_alu_op = ALU_OR;  end
          FN_SLT: begin dec_reg_write = 1'b1; dec_reg_dst = 1'b1; dec_alu_op = ALU_SLT; end
          default: ;
        endcase
      end
      OP_ADDI: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_ADD; end
      OP_SLTI: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_SLT; end
      OP_LW: begin
        dec_mem_read   = 1'b1;
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_src    = 1'b1;
      end
      OP_SW: begin dec_mem_write = 1'b1; dec_alu_src = 1'b1; end
      default: ;
    endcase
  end

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);

  // beq resolves in ID, so it must also wait on any in-flight ALU or load result
  always_comb begin
    load_use = ex_mem_read && (ex_write_reg != 5'd0) &&
               ((ex_write_reg == rs) || ((is_rtype || is_sw || is_beq) && (ex_write_reg == rt)));
    beq_haz  = is_beq &&
               ((ex_reg_write && (ex_write_reg != 5'd0) &&
                 ((ex_write_reg == rs) || (ex_write_reg == rt))) ||
                (mem_mem_read && (mem_write_reg != 5'd0) &&
                 ((mem_write_reg == rs) || (mem_write_reg == rt))));
  end

  always_comb begin
    stall         = rst_n && (load_use || beq_haz);
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    ALU_src       = 1'b0;
    ALU_op        = ALU_ADD;
    branch_taken  = 1'b0;
    branch_target = pc_plus4 + XLEN'({imm_sext[29:0], 2'b00});
    if (is_j) branch_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    if (rst_n && !stall) begin
      mem_write    = dec_mem_write;
      mem_read     = dec_mem_read;
      reg_write    = dec_reg_write;
      reg_dst      = dec_reg_dst;
      mem_to_reg   = dec_mem_to_reg;
      ALU_src      = dec_alu_src;
      ALU_op       = dec_alu_op;
      branch_taken = is_j || (is_beq && (read_data1 == read_data2));
    end
    flush_if = branch_taken;
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed scoreboard bench for id_stage: expectations are queued with each stimulus step and
// drained against the combinational/registered outputs between clock edges.
module tb_id_stage;

  localparam int S_RD1   = 0;
  localparam int S_RD2   = 1;
  localparam int S_CTRL  = 2;
  localparam int S_STALL = 3;
  localparam int S_FLUSH = 4;
  localparam int S_BT    = 5;
  localparam int S_BTGT  = 6;
  localparam int S_SCNT  = 7;
  localparam int S_IMM   = 8;
  localparam int S_RD    = 9;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // {mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src, ALU_op[2:0]}
  localparam logic [8:0] C_NONE = 9'b000000000;
  localparam logic [8:0] C_ADD  = 9'b001100000;
  localparam logic [8:0] C_SUB  = 9'b001100001;
  localparam logic [8:0] C_AND  = 9'b001100010;
  localparam logic [8:0] C_OR   = 9'b001100011;
  localparam logic [8:0] C_SLT  = 9'b001100100;
  localparam logic [8:0] C_ADDI = 9'b001001000;
  localparam logic [8:0] C_SLTI = 9'b001001100;
  localparam logic [8:0] C_LW   = 9'b011011000;
  localparam logic [8:0] C_SW   = 9'b100001000;

  logic        clk, rst_n;
  logic [31:0] instr, pc_plus4;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        ex_mem_read, ex_reg_write;
  logic [4:0]  ex_write_reg;
  logic        mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic        mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src;
  logic [2:0]  ALU_op;
  logic [31:0] read_data1, read_data2, imm_sext;
  logic [4:0]  rs, rt, rd;
  logic        stall, flush_if, branch_taken;
  logic [31:0] branch_target;
  logic [15:0] stall_count;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc_plus4(pc_plus4),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .ALU_src(ALU_src), .ALU_op(ALU_op),
    .read_data1(read_data1), .read_data2(read_data2), .imm_sext(imm_sext),
    .rs(rs), .rt(rt), .rd(rd), .stall(stall), .flush_if(flush_if),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {6'b000000, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD1:   return read_data1;
      S_RD2:   return read_data2;
      S_CTRL:  return 32'({mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src, ALU_op});
      S_STALL: return 32'(stall);
      S_FLUSH: return 32'(flush_if);
      S_BT:    return 32'(branch_taken);
      S_BTGT:  return branch_target;
      S_SCNT:  return 32'(stall_count);
      S_IMM:   return imm_sext;
      S_RD:    return 32'(rd);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = observe(x.sel);
      vectors++;
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_reg_write = 1'b1;
    wb_write_reg = r;
    wb_write_data = d;
    step();
    wb_reg_write = 1'b0;
  endtask

  logic [31:0] tbl_instr [11];
  logic [8:0]  tbl_ctrl  [11];

  initial begin
    rst_n = 1'b0;
    instr = '0; pc_plus4 = '0;
    wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = '0;
    mem_mem_read = 1'b0; mem_write_reg = '0;

    // In reset: hazard and write-back present, both must be ignored
    #3;
    instr = rtype(5'd7, 5'd2, 5'd4, FN_ADD);
    ex_mem_read = 1'b1; ex_write_reg = 5'd7;
    wb_reg_write = 1'b1; wb_write_reg = 5'd7; wb_write_data = 32'h0000_DEAD;
    step(); step();
    expect_val("rst_stall", S_STALL, 32'd0);
    expect_val("rst_ctrl",  S_CTRL,  32'(C_NONE));
    expect_val("rst_bt",    S_BT,    32'd0);
    expect_val("rst_flush", S_FLUSH, 32'd0);
    expect_val("rst_scnt",  S_SCNT,  32'd0);
    expect_val("rst_rd1",   S_RD1,   32'd0);
    drain();

    wb_reg_write = 1'b0; ex_mem_read = 1'b0; ex_write_reg = '0;
    #2 rst_n = 1'b1;
    step();
    expect_val("r7_not_written", S_RD1,  32'd0);
    expect_val("post_rst_add",   S_CTRL, 32'(C_ADD));
    drain();

    // Write-through on the same cycle, then registered value
    instr = rtype(5'd5, 5'd0, 5'd0, FN_ADD);
    wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h0000_1234;
    expect_val("wthru_rd1", S_RD1, 32'h0000_1234);
    drain();
    step();
    wb_reg_write = 1'b0;
    expect_val("r5_stored", S_RD1, 32'h0000_1234);
    drain();

    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);

    tbl_instr[0]  = rtype(5'd1, 5'd2, 5'd4, FN_ADD);        tbl_ctrl[0]  = C_ADD;
    tbl_instr[1]  = rtype(5'd1, 5'd2, 5'd4, FN_SUB);        tbl_ctrl[1]  = C_SUB;
    tbl_instr[2]  = rtype(5'd1, 5'd2, 5'd4, FN_AND);        tbl_ctrl[2]  = C_AND;
    tbl_instr[3]  = rtype(5'd1, 5'd2, 5'd4, FN_OR);         tbl_ctrl[3]  = C_OR;
    tbl_instr[4]  = rtype(5'd1, 5'd2, 5'd4, FN_SLT);        tbl_ctrl[4]  = C_SLT;
    tbl_instr[5]  = rtype(5'd1, 5'd2, 5'd4, 6'b000000);     tbl_ctrl[5]  = C_NONE;
    tbl_instr[6]  = itype(6'b001000, 5'd1, 5'd6, 16'hFFFC); tbl_ctrl[6]  = C_ADDI;
    tbl_instr[7]  = itype(6'b001010, 5'd1, 5'd6, 16'h0010); tbl_ctrl[7]  = C_SLTI;
    tbl_instr[8]  = itype(6'b100011, 5'd1, 5'd6, 16'h0004); tbl_ctrl[8]  = C_LW;
    tbl_instr[9]  = itype(6'b101011, 5'd1, 5'd6, 16'h0004); tbl_ctrl[9]  = C_SW;
    tbl_instr[10] = itype(6'b111111, 5'd1, 5'd6, 16'h0004); tbl_ctrl[10] = C_NONE;
    for (int i = 0; i < 11; i++) begin
      instr = tbl_instr[i];
      expect_val($sformatf("decode_%0d", i), S_CTRL, 32'(tbl_ctrl[i]));
      expect_val($sformatf("nostall_%0d", i), S_STALL, 32'd0);
      drain();
    end

    instr = rtype(5'd1, 5'd2, 5'd4, FN_ADD);
    expect_val("rd1_r1", S_RD1, 32'd7);
    expect_val("rd2_r2", S_RD2, 32'd7);
    expect_val("rd_fld", S_RD,  32'd4);
    drain();
    instr = itype(6'b001000, 5'd1, 5'd6, 16'hFFFC);
    expect_val("imm_neg", S_IMM, 32'hFFFF_FFFC);
    drain();

    // Load-use on rt of an R-type
    instr = rtype(5'd3, 5'd2, 5'd4, FN_ADD);
    instr = rtype(5'd2, 5'd3, 5'd4, FN_ADD);
    ex_mem_read = 1'b1; ex_write_reg = 5'd3;
    expect_val("lu_stall", S_STALL, 32'd1);
    expect_val("lu_ctrl",  S_CTRL,  32'(C_NONE));
    expect_val("lu_bt",    S_BT,    32'd0);
    drain();
    step();
    expect_val("lu_scnt", S_SCNT, 32'd1);
    drain();
    // rt is a destination for lw, so no stall
    instr = itype(6'b100011, 5'd1, 5'd3, 16'h0000);
    expect_val("lw_rt_nostall", S_STALL, 32'd0);
    expect_val("lw_rt_ctrl",    S_CTRL,  32'(C_LW));
    drain();
    // Load into r0 never stalls
    instr = rtype(5'd0, 5'd2, 5'd4, FN_ADD);
    ex_write_reg = 5'd0;
    expect_val("lu_r0_nostall", S_STALL, 32'd0);
    drain();
    ex_mem_read = 1'b0;
    step();
    expect_val("scnt_hold", S_SCNT, 32'd1);
    drain();

    // beq taken / not taken
    pc_plus4 = 32'h0000_0100;
    instr = itype(6'b000100, 5'd1, 5'd2, 16'd4);
    expect_val("beq_bt",    S_BT,    32'd1);
    expect_val("beq_flush", S_FLUSH, 32'd1);
    expect_val("beq_tgt",   S_BTGT,  32'h0000_0110);
    expect_val("beq_ctrl",  S_CTRL,  32'(C_NONE));
    expect_val("beq_stall", S_STALL, 32'd0);
    drain();
    instr = itype(6'b000100, 5'd1, 5'd5, 16'hFFFF);
    expect_val("beqn_bt",    S_BT,    32'd0);
    expect_val("beqn_flush", S_FLUSH, 32'd0);
    expect_val("beqn_tgt",   S_BTGT,  32'h0000_00FC);
    drain();

    // beq hazards against EX ALU result and MEM load
    instr = itype(6'b000100, 5'd1, 5'd2, 16'd4);
    ex_reg_write = 1'b1; ex_write_reg = 5'd1;
    expect_val("bhz_ex_stall", S_STALL, 32'd1);
    expect_val("bhz_ex_bt",    S_BT,    32'd0);
    expect_val("bhz_ex_flush", S_FLUSH, 32'd0);
    drain();
    step();
    expect_val("bhz_ex_scnt", S_SCNT, 32'd2);
    drain();
    ex_reg_write = 1'b0; ex_write_reg = 5'd0;
    mem_mem_read = 1'b1; mem_write_reg = 5'd2;
    expect_val("bhz_mem_stall", S_STALL, 32'd1);
    expect_val("bhz_mem_bt",    S_BT,    32'd0);
    drain();
    step();
    expect_val("bhz_mem_scnt", S_SCNT, 32'd3);
    drain();
    instr = rtype(5'd1, 5'd2, 5'd4, FN_ADD);
    expect_val("mem_hz_nonbeq", S_STALL, 32'd0);
    drain();
    mem_mem_read = 1'b0; mem_write_reg = 5'd0;

    // Jump
    pc_plus4 = 32'h9000_0000;
    instr = {6'b000010, 26'h000_0040};
    expect_val("j_bt",    S_BT,    32'd1);
    expect_val("j_flush", S_FLUSH, 32'd1);
    expect_val("j_tgt",   S_BTGT,  32'h9000_0100);
    expect_val("j_ctrl",  S_CTRL,  32'(C_NONE));
    drain();

    // r0 stays zero even with write-back to it
    instr = rtype(5'd0, 5'd0, 5'd4, FN_ADD);
    wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_write_data = 32'h0000_FFFF;
    expect_val("r0_wthru", S_RD1, 32'd0);
    drain();
    step();
    wb_reg_write = 1'b0;
    expect_val("r0_read", S_RD1, 32'd0);
    drain();

    // Long stall saturates the counter
    instr = rtype(5'd3, 5'd2, 5'd4, FN_ADD);
    ex_mem_read = 1'b1; ex_write_reg = 5'd3;
    repeat (70000) step();
    expect_val("sat_scnt", S_SCNT, 32'h0000_FFFF);
    drain();
    step();
    expect_val("sat_hold",  S_SCNT,  32'h0000_FFFF);
    expect_val("sat_stall", S_STALL, 32'd1);
    drain();

    // Asynchronous reset mid-stall
    #2 rst_n = 1'b0;
    expect_val("mid_rst_scnt",  S_SCNT,  32'd0);
    expect_val("mid_rst_stall", S_STALL, 32'd0);
    expect_val("mid_rst_rd2",   S_RD2,   32'd0);
    drain();
    ex_mem_read = 1'b0; ex_write_reg = 5'd0;
    step();
    rst_n = 1'b1;
    step();
    expect_val("resume_stall", S_STALL, 32'd0);
    expect_val("resume_ctrl",  S_CTRL,  32'(C_ADD));
    expect_val("resume_scnt",  S_SCNT,  32'd0);
    expect_val("resume_rd2",   S_RD2,   32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  async active-low reset.
REQ-004 instr  in  32  instruction from IF/ID register.
REQ-005 pc_plus4  in  32  PC+4 of instr.
REQ-006 wb_reg_write, wb_write_reg, wb_write_data  in  1/5/32  write-back port.
REQ-007 ex_mem_read, ex_reg_write, ex_write_reg  in  1/1/5  hazard info from the ID/EX stage.
REQ-008 mem_mem_read, mem_write_reg  in  1/5  hazard info from the EX/MEM stage.
REQ-009 mem_write, mem_read, reg_write, reg_dst, mem_to_reg, ALU_src  out  1 each  controls to ID/EX.
REQ-010 ALU_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-011 read_data1, read_data2, imm_sext  out  32 each  operands and sign-extended instr[15:0].
REQ-012 rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
REQ-013 stall  out  1  hold PC and IF/ID.
REQ-014 flush_if  out  1  clear IF/ID.
REQ-015 branch_taken, branch_target  out  1/32  PC redirect.
REQ-016 stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 The register file SHALL hold 32x32-bit registers, written on rising clk when wb_reg_write=1 and wb_write_reg!=0.
REQ-018 Register 0 SHALL always read 0.
REQ-019 Reads SHALL be combinational with write-through: same-cycle write to a read register SHALL return wb_write_data.
REQ-020 Decode: R-type 000000 (funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) -> reg_write=1, reg_dst=1, other controls 0.
REQ-021 Decode: addi 001000 -> reg_write, ALU_src, ALU_op=000.
REQ-022 Decode: slti 001010 -> reg_write, ALU_src, ALU_op=100.
REQ-023 Decode: lw 100011 -> mem_read, reg_write, mem_to_reg, ALU_src, ALU_op=000.
REQ-024 Decode: sw 101011 -> mem_write, ALU_src, ALU_op=000.
REQ-025 Decode: beq 000100 and j 000010 -> all ID/EX controls 0.
REQ-026 Unknown opcode or funct SHALL decode as a bubble (all controls 0).
REQ-027 Load-use hazard: ex_mem_read=1, ex_write_reg!=0, and ex_write_reg equals rs, or equals rt when rt is a source (R-type, sw, beq) -> stall=1.
REQ-028 beq hazard: ex_reg_write=1 and ex_write_reg (nonzero) matches rs/rt -> stall=1.
REQ-029 beq hazard: mem_mem_read=1 and mem_write_reg (nonzero) matches rs/rt -> stall=1.
REQ-030 While stall=1, all ID/EX control outputs SHALL be 0, and branch_taken and flush_if SHALL be 0.
REQ-031 beq without stall: branch_taken=1 iff read_data1==read_data2 after write-through.
REQ-032 beq branch_target SHALL be pc_plus4 + (imm_sext<<2), mod 2^32.
REQ-033 j: branch_taken=1, branch_target={pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-034 flush_if SHALL equal branch_taken.
REQ-035 stall_count SHALL increment on each rising clk with stall=1 and hold at 16'hFFFF.

Reset
REQ-036 rst_n low SHALL asynchronously clear all 32 registers and stall_count to 0.
REQ-037 While rst_n is low, all control outputs, stall, flush_if and branch_taken SHALL be 0.
REQ-038 Register-file writes SHALL be ignored while rst_n is low.
REQ-039 A reset asserted mid-stall SHALL clear state; after release, decode SHALL resume with no residual stall.

Verification
REQ-040 Stimulus: wb write r5=0x1234 while reading rs=5 in the same cycle. Required: read_data1=0x1234 that cycle.
REQ-041 Stimulus: lw r3 in EX (ex_mem_read=1, ex_write_reg=3); add r4,r3,r2 in ID. Required: stall=1, all controls 0, stall_count +1.
REQ-042 Stimulus: beq r1,r2,+4 with r1=r2=7 and pc_plus4=0x100, no hazard. Required: branch_taken=1, flush_if=1, branch_target=0x110.
REQ-043 Stimulus: beq with ex_reg_write=1, ex_write_reg=rs. Required: stall=1, branch_taken=0.
REQ-044 Stimulus: wb write to r0=0xFFFF, then read r0. Required: read_data=0; unknown opcode 111111 gives all controls 0.
REQ-045 Stimulus: hold stall for 70000 cycles. Required: stall_count=0xFFFF; rst_n pulse low returns stall_count=0 and registers=0.
